store_diffusion_errors: RTL and testbench

STORE_DIFFUSION_ERRORS -- requirements
Module: store_diffusion_errors

---
 rtl/store_diffusion_errors_pkg.sv | 47 ++++
 rtl/store_diffusion_errors_if.sv | 32 +++
 rtl/store_diffusion_errors_derr_ram.sv | 29 ++
 rtl/store_diffusion_errors.sv | 120 ++++++++++++
 tb/tb_store_diffusion_errors.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/store_diffusion_errors_pkg.sv
// ------------------------------------------------------------------
// store_diffusion_errors_pkg : shared constants, field offsets, FSM
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package store_diffusion_errors_pkg;

  localparam int ADDR_W = 10;

  localparam int DERR_U_E1 = 0;
  localparam int DERR_U_E2 = 8;
  localparam int DERR_U_E3 = 16;
  localparam int DERR_V_E1 = 24;
  localparam int DERR_V_E2 = 32;
  localparam int DERR_V_E3 = 40;

  localparam int TL_U0 = 0;
  localparam int TL_U1 = 8;
  localparam int TL_V0 = 16;
  localparam int TL_V1 = 24;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    CALC  = 4'b0010,
    WRITE = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  // l1 = floor(3*e3/4); 10 bits holds 3*(-128) = -384 without overflow
  function automatic logic [7:0] calc_l1(input logic [7:0] e3);
    logic signed [9:0] e3_w;
    logic signed [9:0] prod;
    logic signed [9:0] sh;
    e3_w = 10'(signed'(e3));
    prod = e3_w + (e3_w <<< 1);
    sh   = prod >>> 2;
    return sh[7:0];
  endfunction

  function automatic logic [7:0] calc_t1(input logic [7:0] e3);
    return e3 - calc_l1(e3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_diffusion_errors_if.sv
// ------------------------------------------------------------------
// store_diffusion_errors_if : store request, top read and status bus
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface store_diffusion_errors_if #(
  parameter int ADDR_W = store_diffusion_errors_pkg::ADDR_W
);
  logic              start;
  logic [ADDR_W-1:0] x;
  logic [47:0]       derr;
  logic              clear_left;
  logic              top_derr_en;
  logic [ADDR_W-1:0] top_derr_addr;
  logic [31:0]       top_derr;
  logic [31:0]       left_derr;
  logic              busy;
  logic              done;

  modport master (
    output start, x, derr, clear_left, top_derr_en, top_derr_addr,
    input  top_derr, left_derr, busy, done
  );

  modport slave (
    input  start, x, derr, clear_left, top_derr_en, top_derr_addr,
    output top_derr, left_derr, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/store_diffusion_errors_derr_ram.sv
// ------------------------------------------------------------------
// derr_ram : simple dual-port RAM, synchronous write and read
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module derr_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/store_diffusion_errors.sv
// ------------------------------------------------------------------
// store_diffusion_errors : splits U/V diffusion errors into left/top
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module store_diffusion_errors #(
  parameter int ADDR_W = store_diffusion_errors_pkg::ADDR_W
) (
  input logic                    clk,
  input logic                    rst_n,
  store_diffusion_errors_if.slave bus
);
  import store_diffusion_errors_pkg::*;

  state_t            state;
  state_t            state_nx;
  logic              latch;
  logic [ADDR_W-1:0] x_q;
  logic [47:0]       derr_q;
  logic [31:0]       top_w_q;
  logic [31:0]       left_w_q;
  logic [31:0]       left_q;
  logic              ram_we;
  logic [31:0]       ram_rd;
  logic              rd_valid_q;
  logic              hit_q;
  logic [31:0]       byp_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    latch    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = CALC;
          latch    = 1'b1;
        end
      end
      CALC:    state_nx = WRITE;
      WRITE:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q      <= '0;
      derr_q   <= '0;
      top_w_q  <= '0;
      left_w_q <= '0;
    end else begin
      if (latch) begin
        x_q    <= bus.x;
        derr_q <= bus.derr;
      end
      if (state == CALC) begin
        left_w_q[TL_U0 +: 8] <= derr_q[DERR_U_E1 +: 8];
        left_w_q[TL_U1 +: 8] <= calc_l1(derr_q[DERR_U_E3 +: 8]);
        left_w_q[TL_V0 +: 8] <= derr_q[DERR_V_E1 +: 8];
        left_w_q[TL_V1 +: 8] <= calc_l1(derr_q[DERR_V_E3 +: 8]);
        top_w_q[TL_U0 +: 8]  <= derr_q[DERR_U_E2 +: 8];
        top_w_q[TL_U1 +: 8]  <= calc_t1(derr_q[DERR_U_E3 +: 8]);
        top_w_q[TL_V0 +: 8]  <= derr_q[DERR_V_E2 +: 8];
        top_w_q[TL_V1 +: 8]  <= calc_t1(derr_q[DERR_V_E3 +: 8]);
      end
    end
  end

  // clear_left takes priority over the WRITE-cycle load
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear_left) left_q <= '0;
    else if (state == WRITE)      left_q <= left_w_q;
  end

  assign bus.left_derr = left_q;

  // Reset in the WRITE cycle aborts the store
  assign ram_we = (state == WRITE) && rst_n;

  derr_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_derr_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (x_q),
    .wr_data (top_w_q),
    .rd_en   (bus.top_derr_en),
    .rd_addr (bus.top_derr_addr),
    .rd_data (ram_rd)
  );

  // RAM returns old data on a collision, so the new word is forwarded here
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      hit_q      <= 1'b0;
      byp_q      <= '0;
    end else if (bus.top_derr_en) begin
      rd_valid_q <= 1'b1;
      hit_q      <= ram_we && (bus.top_derr_addr == x_q);
      byp_q      <= top_w_q;
    end
  end

  assign bus.top_derr = !rd_valid_q ? 32'h0 : (hit_q ? byp_q : ram_rd);

endmodule

`default_nettype wire

// File: tb/tb_store_diffusion_errors.sv
// ------------------------------------------------------------------
// tb_store_diffusion_errors : scoreboard bench for the error store
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_store_diffusion_errors;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [31:0] mem_m [int];
  logic [31:0] exp_left_q [$];
  logic [31:0] exp_rd_q [$];

  store_diffusion_errors_if #(.ADDR_W(10)) bus ();

  store_diffusion_errors #(.ADDR_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] mk(input logic [7:0] u1, input logic [7:0] u2, input logic [7:0] u3,
                                     input logic [7:0] v1, input logic [7:0] v2, input logic [7:0] v3);
    return {v3, v2, v1, u3, u2, u1};
  endfunction

  function automatic logic [7:0] m_l1(input logic [7:0] e);
    int s;
    int v;
    s = int'($signed(e));
    v = 3 * s;
    if (v >= 0) return 8'(v / 4);
    else        return 8'(-((-v + 3) / 4));
  endfunction

  task automatic model(input logic [47:0] d, output logic [31:0] tw, output logic [31:0] lw);
    lw = {m_l1(d[47:40]), d[31:24], m_l1(d[23:16]), d[7:0]};
    tw = {8'(d[47:40] - m_l1(d[47:40])), d[39:32], 8'(d[23:16] - m_l1(d[23:16])), d[15:8]};
  endtask

  task automatic store_op(input logic [9:0] a, input logic [47:0] d, input bit restart,
                          input bit clr, input bit rd, input logic [9:0] ra);
    logic [31:0] tw;
    logic [31:0] lw;
    int k;
    bit seen;
    bit rd_pend;
    model(d, tw, lw);
    check("idle_busy", {31'b0, bus.busy}, 32'h0);
    bus.start = 1'b1;
    bus.x     = a;
    bus.derr  = d;
    exp_left_q.push_back(clr ? 32'h0 : lw);
    k = 0; seen = 0; rd_pend = 0;
    while (!seen && k < 8) begin
      @(negedge clk);
      k++;
      if (rd_pend) begin
        check("rd_in_write", bus.top_derr, exp_rd_q.pop_front());
        rd_pend = 0;
      end
      if (bus.done) begin
        seen = 1;
        check("latency", 32'(k), 32'd3);
        check("left_derr", bus.left_derr, exp_left_q.pop_front());
      end else begin
        check("busy_run", {31'b0, bus.busy}, 32'h1);
      end
      bus.start       = restart && (k <= 3);
      bus.clear_left  = clr && (k == 2);
      bus.top_derr_en = rd && (k == 2);
      if (rd && k == 2) begin
        bus.top_derr_addr = ra;
        exp_rd_q.push_back((ra == a) ? tw : mem_m[int'(ra)]);
        rd_pend = 1;
      end
    end
    check("done_seen", {31'b0, seen}, 32'h1);
    mem_m[int'(a)] = tw;
    @(negedge clk);
    if (rd_pend) check("rd_in_write", bus.top_derr, exp_rd_q.pop_front());
    check("done_pulse", {31'b0, bus.done}, 32'h0);
    check("idle_after", {31'b0, bus.busy}, 32'h0);
    bus.start       = 1'b0;
    bus.clear_left  = 1'b0;
    bus.top_derr_en = 1'b0;
  endtask

  task automatic read_chk(input logic [9:0] ra);
    bus.top_derr_en   = 1'b1;
    bus.top_derr_addr = ra;
    exp_rd_q.push_back(mem_m[int'(ra)]);
    @(negedge clk);
    bus.top_derr_en   = 1'b0;
    bus.top_derr_addr = ~ra;
    check("rd_data", bus.top_derr, exp_rd_q.pop_front());
    @(negedge clk);
    check("rd_hold", bus.top_derr, mem_m[int'(ra)]);
  endtask

  task automatic reset_during(input int k_rst, input logic [9:0] a, input logic [47:0] d);
    bus.start = 1'b1;
    bus.x     = a;
    bus.derr  = d;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == k_rst)     rst_n = 1'b0;
      if (k == k_rst + 1) begin
        rst_n = 1'b1;
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_done", {31'b0, bus.done}, 32'h0);
        check("rst_left", bus.left_derr, 32'h0);
        check("rst_top", bus.top_derr, 32'h0);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.x = '0; bus.derr = '0; bus.clear_left = 1'b0;
    bus.top_derr_en = 1'b0; bus.top_derr_addr = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    check("reset_done", {31'b0, bus.done}, 32'h0);
    check("reset_top", bus.top_derr, 32'h0);
    check("reset_left", bus.left_derr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    store_op(10'd6, mk(8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66), 0, 0, 0, 10'd0);
    store_op(10'd5, mk(8'd3, 8'hFE, 8'd7, 8'hFF, 8'd4, 8'hFB), 0, 0, 1, 10'd5);
    check("ref_left", bus.left_derr, 32'hFCFF0503);
    read_chk(10'd5);
    check("ref_top", bus.top_derr, 32'hFF0402FE);

    store_op(10'd5, mk(8'd9, 8'd8, 8'd40, 8'd7, 8'd6, 8'hC0), 0, 0, 1, 10'd6);
    read_chk(10'd5);

    store_op(10'd9, mk(8'd1, 8'd2, 8'h80, 8'd3, 8'd4, 8'h7F), 1, 0, 0, 10'd0);
    check("bnd_ul1", {24'h0, bus.left_derr[15:8]}, 32'hA0);
    check("bnd_vl1", {24'h0, bus.left_derr[31:24]}, 32'h5F);
    store_op(10'd10, mk(8'd5, 8'd6, 8'd0, 8'd7, 8'd8, 8'd0), 0, 0, 0, 10'd0);
    check("zero_l1", {16'h0, bus.left_derr[31:24], bus.left_derr[15:8]}, 32'h0);
    read_chk(10'd9);
    check("bnd_ut1", {24'h0, bus.top_derr[15:8]}, 32'hE0);
    check("bnd_vt1", {24'h0, bus.top_derr[31:24]}, 32'h20);
    read_chk(10'd10);

    store_op(10'd11, mk(8'h10, 8'h20, 8'h30, 8'hF0, 8'hE0, 8'hD0), 0, 1, 0, 10'd0);
    read_chk(10'd11);

    store_op(10'd0, mk(8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2), 0, 0, 0, 10'd0);
    store_op(10'd1023, mk(8'd9, 8'd9, 8'd9, 8'hF9, 8'hF9, 8'hF9), 0, 0, 0, 10'd0);
    read_chk(10'd0);
    read_chk(10'd1023);

    reset_during(2, 10'd11, mk(8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55));
    read_chk(10'd11);
    reset_during(1, 10'd12, mk(8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66));
    store_op(10'd12, mk(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC), 0, 0, 0, 10'd0);
    read_chk(10'd12);

    check("left_q_empty", 32'(exp_left_q.size()), 32'h0);
    check("rd_q_empty", 32'(exp_rd_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
